// File: rtl/repairmb_pkg.sv
// Shared types for the REPAIRMB lane checker.
// States, bitmap classes and verdict encoding.
package repairmb_pkg;

  typedef enum logic {
    IDLE         = 1'b0,
    WAIT_RECHECK = 1'b1
  } state_e;

  typedef enum logic [1:0] {
    MAP_FULL     = 2'd0,
    MAP_NONE     = 2'd1,
    MAP_DEGRADED = 2'd2,
    MAP_ILLEGAL  = 2'd3
  } map_class_e;

  localparam logic [1:0] V_NONE      = 2'd0;
  localparam logic [1:0] V_CONTINUE  = 2'd1;
  localparam logic [1:0] V_REPEAT    = 2'd2;
  localparam logic [1:0] V_TRAIN_ERR = 2'd3;

endpackage

// File: rtl/repairmb_map_classifier.sv
// Combinational classifier for a lane-group bitmap.
// A half-width map is only legal as exactly the low or high half.
module repairmb_map_classifier
  import repairmb_pkg::*;
#(
  parameter int NUM_GROUPS = 2
) (
  input  logic [NUM_GROUPS-1:0] i_map,
  output map_class_e            o_class
);

  localparam int H = NUM_GROUPS / 2;
  localparam logic [NUM_GROUPS-1:0] LO_HALF = NUM_GROUPS'({H{1'b1}});
  localparam logic [NUM_GROUPS-1:0] HI_HALF = ~LO_HALF;

  // classify the bitmap; the three tests are mutually exclusive
  always_comb begin
    o_class = MAP_ILLEGAL;
    unique case (1'b1)
      (&i_map):  o_class = MAP_FULL;
      (~|i_map): o_class = MAP_NONE;
      (i_map == LO_HALF || i_map == HI_HALF):
                 o_class = MAP_DEGRADED;
      default:   o_class = MAP_ILLEGAL;
    endcase
  end

endmodule

// File: rtl/repairmb_lane_checker.sv
// Partner-side REPAIRMB lane-repair checker.
// Issues continue/repeat/train-error verdicts and tracks re-checks.
module repairmb_lane_checker
  import repairmb_pkg::*;
#(
  parameter int NUM_GROUPS     = 2,
  parameter int MAX_RETRY      = 1,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                           CLK,
  input  logic                           rst,
  input  logic                           i_start_check,
  input  logic [NUM_GROUPS-1:0]          i_lane_map,
  input  logic                           i_dtc_en,
  input  logic                           i_clear,
  output logic                           o_done_check,
  output logic                           o_continue,
  output logic                           o_go_to_repeat,
  output logic                           o_go_to_train_error,
  output logic [NUM_GROUPS-1:0]          o_lane_map,
  output logic [$clog2(MAX_RETRY+1)-1:0] o_retry_cnt,
  output logic                           o_busy
);

  localparam int RW = $clog2(MAX_RETRY + 1);
  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);
  localparam logic [TW-1:0] WAIT_LAST =
    TW'(TIMEOUT_CYCLES > 0 ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);

  state_e                  state_q, state_d;
  logic [1:0]              verdict_q, verdict_d;
  logic                    done_q, done_d;
  logic [NUM_GROUPS-1:0]   map_q, map_d;
  logic [RW-1:0]           retry_q, retry_d;
  logic [TW-1:0]           wait_q, wait_d;
  map_class_e              cls;

  repairmb_map_classifier #(
    .NUM_GROUPS(NUM_GROUPS)
  ) u_cls (
    .i_map   (i_lane_map),
    .o_class (cls)
  );

  // next state, verdict, stored map, retry and wait counters
  always_comb begin
    state_d   = state_q;
    verdict_d = V_NONE;
    done_d    = 1'b0;
    map_d     = map_q;
    retry_d   = retry_q;
    wait_d    = wait_q;
    if (i_clear) begin
      state_d = IDLE;
      retry_d = '0;
      wait_d  = '0;
    end else if (i_start_check) begin
      done_d = 1'b1;
      wait_d = '0;
      if (state_q == IDLE) begin
        if (!i_dtc_en) begin
          unique case (cls)
            MAP_FULL: begin
              verdict_d = V_CONTINUE;
              map_d     = i_lane_map;
              retry_d   = '0;
            end
            MAP_DEGRADED: begin
              verdict_d = V_REPEAT;
              map_d     = i_lane_map;
              retry_d   = RW'(1);
              state_d   = WAIT_RECHECK;
            end
            default: begin
              verdict_d = V_TRAIN_ERR;
              retry_d   = '0;
            end
          endcase
        end
      end else begin
        if (i_lane_map == map_q) begin
          verdict_d = V_CONTINUE;
          state_d   = IDLE;
        end else if (cls == MAP_DEGRADED && retry_q < RETRY_MAX) begin
          verdict_d = V_REPEAT;
          map_d     = i_lane_map;
          retry_d   = retry_q + RW'(1);
        end else begin
          verdict_d = V_TRAIN_ERR;
          state_d   = IDLE;
        end
      end
    end else if (TO_EN && state_q == WAIT_RECHECK) begin
      if (wait_q == WAIT_LAST) begin
        verdict_d = V_TRAIN_ERR;
        state_d   = IDLE;
        wait_d    = '0;
      end else begin
        wait_d = wait_q + TW'(1);
      end
    end
  end

  // registered state and outputs
  always_ff @(posedge CLK or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      verdict_q <= V_NONE;
      done_q    <= 1'b0;
      map_q     <= '0;
      retry_q   <= '0;
      wait_q    <= '0;
    end else begin
      state_q   <= state_d;
      verdict_q <= verdict_d;
      done_q    <= done_d;
      map_q     <= map_d;
      retry_q   <= retry_d;
      wait_q    <= wait_d;
    end
  end

  assign o_done_check        = done_q;
  assign o_continue          = (verdict_q == V_CONTINUE);
  assign o_go_to_repeat      = (verdict_q == V_REPEAT);
  assign o_go_to_train_error = (verdict_q == V_TRAIN_ERR);
  assign o_lane_map          = map_q;
  assign o_retry_cnt         = retry_q;
  assign o_busy              = (state_q == WAIT_RECHECK);

endmodule

// File: tb/tb_repairmb_lane_checker.sv
// Scoreboard bench for repairmb_lane_checker.
// Two instances: 2 groups with timeout, 4 groups with two retries.
module tb_repairmb_lane_checker;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic        a_start, a_dtc, a_clr;
  logic [1:0]  a_map;
  logic        a_done, a_cont, a_rep, a_terr;
  logic [1:0]  a_omap;
  logic        a_rc;
  logic        a_busy;

  logic        b_start, b_dtc, b_clr;
  logic [3:0]  b_map;
  logic        b_done, b_cont, b_rep, b_terr;
  logic [3:0]  b_omap;
  logic [1:0]  b_rc;
  logic        b_busy;

  int errors = 0;
  int checks = 0;
  logic [31:0] cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [31:0] when;
    logic [3:0]  pulse;
    logic [3:0]  map;
    logic [1:0]  rc;
    logic        busy;
  } exp_t;

  exp_t qa[$];
  exp_t qb[$];

  repairmb_lane_checker #(
    .NUM_GROUPS(2), .MAX_RETRY(1), .TIMEOUT_CYCLES(8)
  ) u_a (
    .CLK(clk), .rst(rst),
    .i_start_check(a_start), .i_lane_map(a_map),
    .i_dtc_en(a_dtc), .i_clear(a_clr),
    .o_done_check(a_done), .o_continue(a_cont),
    .o_go_to_repeat(a_rep), .o_go_to_train_error(a_terr),
    .o_lane_map(a_omap), .o_retry_cnt(a_rc), .o_busy(a_busy)
  );

  repairmb_lane_checker #(
    .NUM_GROUPS(4), .MAX_RETRY(2), .TIMEOUT_CYCLES(0)
  ) u_b (
    .CLK(clk), .rst(rst),
    .i_start_check(b_start), .i_lane_map(b_map),
    .i_dtc_en(b_dtc), .i_clear(b_clr),
    .o_done_check(b_done), .o_continue(b_cont),
    .o_go_to_repeat(b_rep), .o_go_to_train_error(b_terr),
    .o_lane_map(b_omap), .o_retry_cnt(b_rc), .o_busy(b_busy)
  );

  function automatic void check(string name, logic [63:0] act,
                                logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endfunction

  // monitor for instance A
  always @(negedge clk) begin
    exp_t act, e;
    if (!rst && (a_done | a_cont | a_rep | a_terr)) begin
      act = '{cyc, {a_done, a_cont, a_rep, a_terr},
              {2'b00, a_omap}, {1'b0, a_rc}, a_busy};
      if (qa.size() == 0) begin
        check("a_unexpected", act, '0);
      end else begin
        e = qa.pop_front();
        check("a_out", act, e);
      end
    end
  end

  // monitor for instance B
  always @(negedge clk) begin
    exp_t act, e;
    if (!rst && (b_done | b_cont | b_rep | b_terr)) begin
      act = '{cyc, {b_done, b_cont, b_rep, b_terr},
              b_omap, b_rc, b_busy};
      if (qb.size() == 0) begin
        check("b_unexpected", act, '0);
      end else begin
        e = qb.pop_front();
        check("b_out", act, e);
      end
    end
  end

  task automatic drv_a(input logic s, input logic [1:0] m,
                       input logic d, input logic c);
    @(posedge clk); #1;
    a_start = s; a_map = m; a_dtc = d; a_clr = c;
  endtask

  task automatic drv_b(input logic s, input logic [3:0] m,
                       input logic d, input logic c);
    @(posedge clk); #1;
    b_start = s; b_map = m; b_dtc = d; b_clr = c;
  endtask

  task automatic idle_a(input int n);
    repeat (n) drv_a(1'b0, a_map, 1'b0, 1'b0);
  endtask

  task automatic idle_b(input int n);
    repeat (n) drv_b(1'b0, b_map, 1'b0, 1'b0);
  endtask

  // pulse = {done, continue, repeat, train_error}
  task automatic ck_a(input logic [1:0] m, input logic d,
                      input logic [3:0] p, input logic [3:0] em,
                      input logic [1:0] rc, input logic bz);
    drv_a(1'b1, m, d, 1'b0);
    qa.push_back('{cyc + 1, p, em, rc, bz});
  endtask

  task automatic ck_b(input logic [3:0] m, input logic d,
                      input logic [3:0] p, input logic [3:0] em,
                      input logic [1:0] rc, input logic bz);
    drv_b(1'b1, m, d, 1'b0);
    qb.push_back('{cyc + 1, p, em, rc, bz});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    a_start = 0; a_map = 0; a_dtc = 0; a_clr = 0;
    b_start = 0; b_map = 0; b_dtc = 0; b_clr = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_a", {a_done, a_cont, a_rep, a_terr, a_omap, a_rc, a_busy}, '0);
    check("reset_b", {b_done, b_cont, b_rep, b_terr, b_omap, b_rc, b_busy}, '0);

    // full map continues
    ck_a(2'b11, 0, 4'b1100, 4'd3, 2'd0, 0);
    // degraded then matching re-check
    ck_a(2'b01, 0, 4'b1010, 4'd1, 2'd1, 1);
    ck_a(2'b01, 0, 4'b1100, 4'd1, 2'd1, 0);
    // empty map errors, map kept
    ck_a(2'b00, 0, 4'b1001, 4'd1, 2'd0, 0);
    // DTC first check: done only
    ck_a(2'b01, 1, 4'b1000, 4'd1, 2'd0, 0);
    idle_a(1);

    // timeout 8 cycles after entry
    ck_a(2'b10, 0, 4'b1010, 4'd2, 2'd1, 1);
    qa.push_back('{cyc + 9, 4'b0001, 4'd2, 2'd1, 1'b0});
    idle_a(12);

    // start on the expiry cycle wins
    ck_a(2'b10, 0, 4'b1010, 4'd2, 2'd1, 1);
    idle_a(7);
    ck_a(2'b10, 0, 4'b1100, 4'd2, 2'd1, 0);
    idle_a(12);

    // retries exhausted at MAX_RETRY=1
    ck_a(2'b01, 0, 4'b1010, 4'd1, 2'd1, 1);
    ck_a(2'b10, 0, 4'b1001, 4'd1, 2'd1, 0);
    idle_a(2);

    // clear with start: nothing emitted
    ck_a(2'b10, 0, 4'b1010, 4'd2, 2'd1, 1);
    drv_a(1'b1, 2'b10, 1'b0, 1'b1);
    drv_a(1'b0, 2'b10, 1'b0, 1'b0);
    check("clear_state", {a_busy, a_rc, a_omap}, {1'b0, 1'b0, 2'b10});
    idle_a(12);

    // B: two repeats then error
    ck_b(4'b0011, 0, 4'b1010, 4'd3,  2'd1, 1);
    ck_b(4'b1100, 0, 4'b1010, 4'd12, 2'd2, 1);
    ck_b(4'b0011, 0, 4'b1001, 4'd12, 2'd2, 0);
    // illegal map
    ck_b(4'b0110, 0, 4'b1001, 4'd12, 2'd0, 0);
    ck_b(4'b1111, 0, 4'b1100, 4'd15, 2'd0, 0);
    // no timeout when disabled; DTC ignored in re-check
    ck_b(4'b1100, 0, 4'b1010, 4'd12, 2'd1, 1);
    idle_b(20);
    ck_b(4'b1100, 1, 4'b1100, 4'd12, 2'd1, 0);
    // two repeats then matching re-check
    ck_b(4'b0011, 0, 4'b1010, 4'd3,  2'd1, 1);
    ck_b(4'b1100, 0, 4'b1010, 4'd12, 2'd2, 1);
    ck_b(4'b1100, 0, 4'b1100, 4'd12, 2'd2, 0);
    idle_b(3);

    // async reset mid-wait
    ck_a(2'b01, 0, 4'b1010, 4'd1, 2'd1, 1);
    idle_a(3);
    check("busy_before_rst", {63'd0, a_busy}, 64'd1);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("async_rst_a", {a_done, a_cont, a_rep, a_terr, a_omap, a_rc, a_busy}, '0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_a(12);

    idle_b(2);
    check("a_queue_empty", 64'(qa.size()), 64'd0);
    check("b_queue_empty", 64'(qb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
